register_file_r_en: RTL

Parametrised multi-entry register file built from enable-gated, asynchronously reset storage registers. It replaces hand-instantiated fixed-width registers wherever the datapath needs addressable storage: FIFO/buffer memories, configuration banks and scratch storage. It provides one write port, two independently registered read ports, per-entry valid tracking, optional write-to-read bypass, and a synchronous bulk clear.

---
 rtl/register_file_r_en_pkg.sv | 21 ++
 rtl/register_file_r_en_if.sv | 36 +++
 rtl/register_file_r_en_reg.sv | 31 +++
 rtl/register_file_r_en.sv | 122 ++++++++++++
 4 files changed

// File: rtl/register_file_r_en_pkg.sv
// Shared definitions for the register file slice:
// default geometry, bypass selectors and a constant log2 helper.
package regfile_defs;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;

   localparam bit BYPASS_ON  = 1'b1;
   localparam bit BYPASS_OFF = 1'b0;

   // Smallest r with 2**r >= v; bounded loop keeps it a constant function.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/register_file_r_en_if.sv
// Write/read/status bundle of the register file.
// The master drives requests; the slave (the register file) answers.
interface register_file_r_en_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic              clr;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic              re0;
   logic              re1;
   logic [ADDR_W-1:0] raddr0;
   logic [ADDR_W-1:0] raddr1;
   logic [WIDTH-1:0]  rdata0;
   logic [WIDTH-1:0]  rdata1;
   logic              rvalid0;
   logic              rvalid1;
   logic              rhit0;
   logic              rhit1;
   logic              err;

   modport master (
      output clr, we, waddr, wdata,
      output re0, re1, raddr0, raddr1,
      input  rdata0, rdata1, rvalid0, rvalid1,
      input  rhit0, rhit1, err
   );

   modport slave (
      input  clr, we, waddr, wdata,
      input  re0, re1, raddr0, raddr1,
      output rdata0, rdata1, rvalid0, rvalid1,
      output rhit0, rhit1, err
   );
endinterface

// File: rtl/register_file_r_en_reg.sv
// One storage entry: enable-gated register, async active-low
// reset, and a synchronous clear that loads zero ahead of the enable.
module register_r_en_param #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next value: clear wins, otherwise load when enabled.
   always_comb begin
      q_d = q_q;
      if (clr)     q_d = '0;
      else if (en) q_d = d;
   end

   // Storage flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/register_file_r_en.sv
// Addressable register file: one write port, two registered read
// ports, per-entry valid bits, optional write bypass, sticky range error.
module register_file_r_en
   import regfile_defs::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter bit BYPASS = BYPASS_ON
) (
   input  logic                clk,
   input  logic                reset_n,
   register_file_r_en_if.slave bus
);
   localparam int ADDR_W = clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   logic              w_oor;
   logic [1:0]        r_oor;
   logic [1:0]        re_v;
   logic [ADDR_W-1:0] ra_v [2];

   logic [WIDTH-1:0]  ent_q [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [WIDTH-1:0]  rdata_q [2];
   logic [WIDTH-1:0]  rdata_d [2];
   logic [1:0]        rvalid_q, rvalid_d;
   logic [1:0]        rhit_q, rhit_d;
   logic              err_q, err_d;

   assign re_v     = {bus.re1, bus.re0};
   assign ra_v[0]  = bus.raddr0;
   assign ra_v[1]  = bus.raddr1;
   assign w_oor    = {1'b0, bus.waddr} >= LIMIT;
   assign r_oor[0] = {1'b0, bus.raddr0} >= LIMIT;
   assign r_oor[1] = {1'b0, bus.raddr1} >= LIMIT;

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic en;
      assign en = bus.we & ~w_oor
                & (bus.waddr == ADDR_W'(i));
      register_r_en_param #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk   (clk),
         .rst_n (reset_n),
         .clr   (bus.clr),
         .en    (en),
         .d     (bus.wdata),
         .q     (ent_q[i])
      );
   end

   // Valid bits track which entries were written since reset/clear.
   always_comb begin
      valid_d = valid_q;
      if (bus.clr) begin
         valid_d = '0;
      end else if (bus.we && !w_oor) begin
         valid_d[bus.waddr] = 1'b1;
      end
   end

   // Read ports see pre-write contents unless bypass forwards wdata.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata_d[p]  = rdata_q[p];
         rhit_d[p]   = rhit_q[p];
         rvalid_d[p] = re_v[p];
         if (re_v[p]) begin
            if (r_oor[p]) begin
               rdata_d[p] = '0;
               rhit_d[p]  = 1'b0;
            end else if (BYPASS && bus.we && !w_oor
                         && bus.waddr == ra_v[p]) begin
               rdata_d[p] = bus.wdata;
               rhit_d[p]  = 1'b1;
            end else begin
               rdata_d[p] = ent_q[ra_v[p]];
               rhit_d[p]  = valid_q[ra_v[p]];
            end
         end
      end
   end

   // Sticky error: set by any out-of-range access, dropped by clear.
   always_comb begin
      err_d = err_q;
      if (bus.clr) begin
         err_d = 1'b0;
      end else if ((bus.we && w_oor)
                   || (bus.re0 && r_oor[0])
                   || (bus.re1 && r_oor[1])) begin
         err_d = 1'b1;
      end
   end

   // State registers for valid bits, read outputs and error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= '0;
         rdata_q  <= '{default: '0};
         rvalid_q <= '0;
         rhit_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rhit_q   <= rhit_d;
         err_q    <= err_d;
      end
   end

   assign bus.rdata0  = rdata_q[0];
   assign bus.rdata1  = rdata_q[1];
   assign bus.rvalid0 = rvalid_q[0];
   assign bus.rvalid1 = rvalid_q[1];
   assign bus.rhit0   = rhit_q[0];
   assign bus.rhit1   = rhit_q[1];
   assign bus.err     = err_q;

endmodule
